// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the N-bank line-buffer SRAM controller:
// one-hot FSM encodings, mode bit positions and the bank-pointer wrap helper.
package sram_ctrl_pkg;

   localparam logic [3:0] ST_IDLE = 4'b0001;
   localparam logic [3:0] ST_WR   = 4'b0010;
   localparam logic [3:0] ST_RD   = 4'b0100;
   localparam logic [3:0] ST_WRRD = 4'b1000;

   localparam int unsigned MODE_CNN_MSB = 2;
   localparam int unsigned MODE_FC_BIT  = 3;

   // Explicit wrap at nbank-1 so non-power-of-two bank counts never alias.
   function automatic int unsigned bank_inc(input int unsigned idx, input int unsigned nbank);
      return (idx >= nbank - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/sram_bank_port.sv
// One line-buffer bank: decodes CE/WE from the accepted accesses and holds the
// storage array with a registered read port (1-cycle latency).
module sram_bank_port #(
   parameter int unsigned AW      = 10,
   parameter int unsigned DW      = 128,
   parameter int unsigned BW      = 2,
   parameter int unsigned BANK_ID = 0
) (
   input  logic          SYS_CLK,
   input  logic          wr_acc_i,
   input  logic [BW-1:0] wr_bank_i,
   input  logic [AW-1:0] wr_word_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          rd_acc_i,
   input  logic [BW-1:0] rd_bank_i,
   input  logic [AW-1:0] rd_word_i,
   output logic [DW-1:0] rdata_o
);

   localparam logic [BW-1:0] BANK_SEL = BW'(BANK_ID);

   logic          ce;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] dout_q;

   assign we   = wr_acc_i & (wr_bank_i == BANK_SEL);
   assign ce   = we | (rd_acc_i & (rd_bank_i == BANK_SEL));
   assign addr = we ? wr_word_i : rd_word_i;

   // Storage has no reset; validity of the read data is tracked by the controller.
   always_ff @(posedge SYS_CLK) begin
      if (ce) begin
         if (we) mem_q[addr] <= wdata_i;
         else    dout_q      <= mem_q[addr];
      end
   end

   assign rdata_o = dout_q;

endmodule

// File: rtl/gen_sram_nbank_ctrl.sv
// N-bank line-buffer SRAM controller: rotates write/read bank roles, enforces
// per-bank access rights and returns read data one cycle later with its bank tag.
module gen_sram_nbank_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter  int unsigned AW    = 10,
   parameter  int unsigned DW    = 128,
   parameter  int unsigned NBANK = 3,
   localparam int unsigned BW    = $clog2(NBANK)
) (
   input  logic             SYS_CLK,
   input  logic             SYS_NRST,
   input  logic [3:0]       mode_i,
   input  logic             start_i,
   input  logic             eop_i,
   input  logic [DW-1:0]    wdata_i,
   input  logic             wdata_vld_i,
   input  logic [BW+AW-1:0] waddr_i,
   input  logic [BW+AW-1:0] raddr_i,
   input  logic             raddr_vld_i,
   input  logic             wr_rotate_i,
   input  logic             rd_done_i,
   input  logic             wr2rd_i,
   input  logic             rd2idle_i,
   output logic [DW-1:0]    rdata_o,
   output logic             rdata_vld_o,
   output logic [BW-1:0]    rdata_bank_o,
   output logic [3:0]       state_o,
   output logic [BW-1:0]    wbank_o,
   output logic             err_o
);

   localparam logic [BW:0]   NBANK_W    = (BW+1)'(NBANK);
   localparam logic [BW-1:0] PRIME_LAST = BW'(NBANK - 2);

   function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
      return BW'(bank_inc(32'(p), NBANK));
   endfunction

   logic [3:0]    state_q, state_d;
   logic [BW-1:0] wr_ptr_q, wr_ptr_d;
   logic [BW-1:0] rd_ptr_q, rd_ptr_d;
   logic [BW-1:0] prime_q, prime_d;
   logic [3:0]    mode_q, mode_d;
   logic          err_q, err_d;
   logic          rd_vld_q;
   logic [BW-1:0] rd_bank_q;
   logic          start_err;

   logic [BW-1:0] wbank, rbank;
   logic [AW-1:0] wword, rword;
   logic          wbank_ok, rbank_ok;
   logic          wr_acc, rd_acc;
   logic          mode_ok, is_cnn, is_fc;
   logic [DW-1:0] bank_rdata [NBANK];

   assign {wbank, wword} = waddr_i;
   assign {rbank, rword} = raddr_i;
   assign wbank_ok = {1'b0, wbank} < NBANK_W;
   assign rbank_ok = {1'b0, rbank} < NBANK_W;

   assign mode_ok = (|mode_i[MODE_CNN_MSB:0]) ^ mode_i[MODE_FC_BIT];
   assign is_cnn  = |mode_q[MODE_CNN_MSB:0];
   assign is_fc   = mode_q[MODE_FC_BIT];

   assign wr_acc = wdata_vld_i & wbank_ok & (wbank == wr_ptr_q)
                 & ((state_q == ST_WR) | (state_q == ST_WRRD));
   assign rd_acc = raddr_vld_i & rbank_ok
                 & (((state_q == ST_WRRD) & (rbank != wr_ptr_q))
                  | ((state_q == ST_RD)   & (rbank == rd_ptr_q)));

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      prime_d   = prime_q;
      mode_d    = mode_q;
      start_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (mode_ok) begin
                  state_d  = ST_WR;
                  wr_ptr_d = '0;
                  prime_d  = '0;
                  mode_d   = mode_i;
               end else begin
                  start_err = 1'b1;
               end
            end
         end
         ST_WR: begin
            if (wr_rotate_i) begin
               wr_ptr_d = ptr_inc(wr_ptr_q);
               prime_d  = prime_q + BW'(1);
            end
            // CNN leaves on the priming rotate; FC leaves on end of packet.
            if (is_cnn) begin
               if (wr_rotate_i && (prime_q == PRIME_LAST)) state_d = ST_WRRD;
            end else if (is_fc && eop_i) begin
               state_d  = ST_RD;
               rd_ptr_d = '0;
            end
         end
         ST_WRRD: begin
            if (wr_rotate_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (wr2rd_i) begin
               state_d  = ST_RD;
               rd_ptr_d = ptr_inc(wr_ptr_q);
            end
         end
         ST_RD: begin
            if (rd2idle_i)      state_d  = ST_IDLE;
            else if (rd_done_i) rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign err_d = start_err | (wdata_vld_i & ~wr_acc) | (raddr_vld_i & ~rd_acc);

   always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
      if (!SYS_NRST) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         prime_q   <= '0;
         mode_q    <= '0;
         err_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_bank_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         prime_q  <= prime_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
         rd_vld_q <= rd_acc;
         if (rd_acc) rd_bank_q <= rbank;
      end
   end

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      sram_bank_port #(
         .AW      (AW),
         .DW      (DW),
         .BW      (BW),
         .BANK_ID (b)
      ) u_bank (
         .SYS_CLK   (SYS_CLK),
         .wr_acc_i  (wr_acc),
         .wr_bank_i (wbank),
         .wr_word_i (wword),
         .wdata_i   (wdata_i),
         .rd_acc_i  (rd_acc),
         .rd_bank_i (rbank),
         .rd_word_i (rword),
         .rdata_o   (bank_rdata[b])
      );
   end

   assign rdata_o      = rd_vld_q ? bank_rdata[rd_bank_q] : '0;
   assign rdata_vld_o  = rd_vld_q;
   assign rdata_bank_o = rd_vld_q ? rd_bank_q : '0;
   assign state_o      = state_q;
   assign wbank_o      = wr_ptr_q;
   assign err_o        = err_q;

endmodule
